cvxif_offload_ctrl: RTL and testbench

Core-side CVXIF initiator.
- Takes offloadable instructions from the core issue stage and drives the CVXIF issue handshake.
- Tracks accepted instructions in a small outstanding-ID table, forwards commit/kill, and accepts coprocessor results.
- Returns results to the core writeback port.
- Sits between the core execute/commit logic and any CVXIF coprocessor (cvxif_req_t out, cvxif_resp_t in).

---
 rtl/cvxif_offload_ctrl_pkg.sv | 23 ++
 rtl/cvxif_pkg.sv | 88 ++++++++
 rtl/cvxif_offload_ctrl_if.sv | 12 +
 rtl/cvxif_offload_ctrl_id_table.sv | 98 +++++++++
 rtl/cvxif_offload_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_cvxif_offload_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/cvxif_offload_ctrl_pkg.sv
// Types local to the core-side CV-X-IF offload controller.
package cvxif_offload_ctrl_pkg;

  import cvxif_pkg::*;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } offload_state_e;

  typedef struct packed {
    logic                  valid;
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            rd;
    logic                  writeback;
  } outstanding_entry_t;

  // Destination register field of a standard 32-bit RISC-V encoding.
  function automatic logic [4:0] instr_rd(input logic [31:0] instr);
    return instr[11:7];
  endfunction

endpackage

// File: rtl/cvxif_pkg.sv
// CV-X-IF request/response types shared between the core and its coprocessors.
package cvxif_pkg;

  localparam int unsigned X_ID_WIDTH = 4;
  localparam int unsigned X_NUM_RS   = 2;

  typedef struct packed {
    logic [15:0]           instr;
    logic [X_ID_WIDTH-1:0] id;
  } x_compressed_req_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        accept;
  } x_compressed_resp_t;

  typedef struct packed {
    logic [31:0]                instr;
    logic [X_ID_WIDTH-1:0]      id;
    logic [X_NUM_RS-1:0][31:0]  rs;
    logic [X_NUM_RS-1:0]        rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  x_commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           addr;
    logic                  we;
    logic [31:0]           wdata;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
  } x_mem_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           rdata;
    logic                  err;
  } x_mem_result_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           data;
    logic [4:0]            rd;
    logic                  we;
    logic                  exc;
    logic [5:0]            exccode;
  } x_result_t;

  typedef struct packed {
    logic              x_compressed_valid;
    x_compressed_req_t x_compressed_req;
    logic              x_issue_valid;
    x_issue_req_t      x_issue_req;
    logic              x_commit_valid;
    x_commit_t         x_commit;
    logic              x_mem_ready;
    x_mem_resp_t       x_mem_resp;
    logic              x_mem_result_valid;
    x_mem_result_t     x_mem_result;
    logic              x_result_ready;
  } cvxif_req_t;

  typedef struct packed {
    logic               x_compressed_ready;
    x_compressed_resp_t x_compressed_resp;
    logic               x_issue_ready;
    x_issue_resp_t      x_issue_resp;
    logic               x_mem_valid;
    x_mem_req_t         x_mem_req;
    logic               x_result_valid;
    x_result_t          x_result;
  } cvxif_resp_t;

endpackage

// File: rtl/cvxif_offload_ctrl_if.sv
// CV-X-IF bundle: master = core side (drives req), slave = coprocessor side.
interface cvxif_offload_ctrl_if;

  import cvxif_pkg::*;

  cvxif_req_t  req;
  cvxif_resp_t resp;

  modport master (output req, input  resp);
  modport slave  (input  req, output resp);

endinterface

// File: rtl/cvxif_offload_ctrl_id_table.sv
// Outstanding-instruction table: allocates the lowest free slot, looks up
// result IDs, frees on result or kill. A killed slot remembers its ID until
// the late result shows up or the slot is reused, so that result can be
// dropped silently instead of being flagged as spurious.
module cvxif_id_table
  import cvxif_offload_ctrl_pkg::*;
#(
  parameter int NrEntries = 4,
  parameter int IdWidth   = cvxif_pkg::X_ID_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               alloc_i,
  input  logic [IdWidth-1:0] alloc_id_i,
  input  logic [4:0]         alloc_rd_i,
  input  logic               alloc_wb_i,
  input  logic               kill_i,
  input  logic [IdWidth-1:0] kill_id_i,
  input  logic               lookup_i,
  input  logic [IdWidth-1:0] lookup_id_i,
  output logic               full_o,
  output logic               hit_o,
  output logic               dropped_o,
  output logic [4:0]         match_rd_o,
  output logic               match_wb_o
);

  localparam int IdxW = $clog2(NrEntries);

  outstanding_entry_t   tbl_q [NrEntries];
  logic [NrEntries-1:0] killed_q;

  logic [NrEntries-1:0] valid_vec;
  logic [NrEntries-1:0] live_hit;
  logic [NrEntries-1:0] killed_hit;
  logic [NrEntries-1:0] kill_hit;
  logic [IdxW-1:0]      match_idx;
  logic [IdxW-1:0]      free_idx;
  logic                 kill_same;

  // Per-slot ID compares against the result ID and the kill ID.
  always_comb begin
    valid_vec  = '0;
    live_hit   = '0;
    killed_hit = '0;
    kill_hit   = '0;
    for (int i = 0; i < NrEntries; i++) begin
      valid_vec[i]  = tbl_q[i].valid;
      live_hit[i]   = tbl_q[i].valid && (tbl_q[i].id == lookup_id_i);
      killed_hit[i] = killed_q[i] && !tbl_q[i].valid && (tbl_q[i].id == lookup_id_i);
      kill_hit[i]   = kill_i && tbl_q[i].valid && (tbl_q[i].id == kill_id_i);
    end
  end

  // Lowest matching slot and lowest free slot.
  always_comb begin
    match_idx = '0;
    free_idx  = '0;
    for (int i = NrEntries - 1; i >= 0; i--) begin
      if (live_hit[i])      match_idx = IdxW'(i);
      if (!tbl_q[i].valid)  free_idx  = IdxW'(i);
    end
  end

  // A kill landing in the same cycle as the result wins over the result.
  assign kill_same  = kill_i && (kill_id_i == lookup_id_i) && (|live_hit);
  assign hit_o      = (|live_hit) && !kill_same;
  assign dropped_o  = kill_same || ((|killed_hit) && !(|live_hit));
  assign full_o     = &valid_vec;
  assign match_rd_o = tbl_q[match_idx].rd;
  assign match_wb_o = tbl_q[match_idx].writeback;

  // Slot updates: kill, free on result, allocate into the lowest free slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrEntries; i++) tbl_q[i] <= '0;
      killed_q <= '0;
    end else begin
      for (int i = 0; i < NrEntries; i++) begin
        if (kill_hit[i]) begin
          tbl_q[i].valid <= 1'b0;
          killed_q[i]    <= !(lookup_i && kill_same);
        end else if (lookup_i && hit_o && (IdxW'(i) == match_idx)) begin
          tbl_q[i].valid <= 1'b0;
        end
        if (lookup_i && killed_hit[i]) killed_q[i] <= 1'b0;
        if (alloc_i && (IdxW'(i) == free_idx)) begin
          tbl_q[i].valid     <= 1'b1;
          tbl_q[i].id        <= alloc_id_i;
          tbl_q[i].rd        <= alloc_rd_i;
          tbl_q[i].writeback <= alloc_wb_i;
          killed_q[i]        <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/cvxif_offload_ctrl.sv
// Core-side CV-X-IF initiator: issues offloaded instructions, forwards
// commit/kill, tracks outstanding IDs and buffers one result for writeback.
//
// state | meaning
// IDLE  | waiting for the core to offer an instruction (ready if table not full)
// ISSUE | x_issue_valid held with the registered request until x_issue_ready
module cvxif_offload_ctrl
  import cvxif_pkg::*;
  import cvxif_offload_ctrl_pkg::*;
#(
  parameter int NrOutstanding = 4,
  parameter int IdWidth       = X_ID_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               off_valid_i,
  output logic               off_ready_o,
  input  logic [31:0]        off_instr_i,
  input  logic [31:0]        off_rs1_i,
  input  logic [31:0]        off_rs2_i,
  input  logic [IdWidth-1:0] off_id_i,
  output logic               off_done_o,
  output logic               off_accept_o,
  output logic [IdWidth-1:0] off_done_id_o,
  input  logic               commit_valid_i,
  input  logic               commit_kill_i,
  input  logic [IdWidth-1:0] commit_id_i,
  output logic               wb_valid_o,
  input  logic               wb_ready_i,
  output logic [IdWidth-1:0] wb_id_o,
  output logic [31:0]        wb_data_o,
  output logic [4:0]         wb_rd_o,
  output logic               wb_we_o,
  output logic               wb_exc_o,
  output logic [5:0]         wb_exccode_o,
  output logic               spurious_o,
  cvxif_offload_ctrl_if.master cvxif
);

  offload_state_e state_q, state_d;

  logic [31:0]        instr_q, rs1_q, rs2_q;
  logic [IdWidth-1:0] id_q;
  logic               capture, issue_valid, issue_done;

  logic               tbl_full, tbl_hit, tbl_dropped, tbl_wb;
  logic [4:0]         tbl_rd;
  logic               result_ready, result_hs;

  logic               wb_valid_q, wb_we_q, wb_exc_q;
  logic [IdWidth-1:0] wb_id_q;
  logic [31:0]        wb_data_q;
  logic [4:0]         wb_rd_q;
  logic [5:0]         wb_exccode_q;

  logic               unused_resp;

  // Issue FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Issue FSM next state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    off_ready_o = 1'b0;
    capture     = 1'b0;
    issue_valid = 1'b0;
    issue_done  = 1'b0;
    case (state_q)
      IDLE: begin
        off_ready_o = !tbl_full;
        if (off_valid_i && !tbl_full) begin
          capture = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        issue_valid = 1'b1;
        if (cvxif.resp.x_issue_ready) begin
          issue_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request register, held stable for the whole ISSUE phase.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      id_q    <= '0;
    end else if (capture) begin
      instr_q <= off_instr_i;
      rs1_q   <= off_rs1_i;
      rs2_q   <= off_rs2_i;
      id_q    <= off_id_i;
    end
  end

  assign off_done_o    = issue_done;
  assign off_accept_o  = issue_done && cvxif.resp.x_issue_resp.accept;
  assign off_done_id_o = issue_done ? id_q : '0;

  // Result path: one-entry skid buffer towards the core writeback port.
  assign result_ready = !wb_valid_q || wb_ready_i;
  assign result_hs    = cvxif.resp.x_result_valid && result_ready;
  assign spurious_o   = result_hs && !tbl_hit && !tbl_dropped;

  cvxif_id_table #(
    .NrEntries (NrOutstanding),
    .IdWidth   (IdWidth)
  ) i_id_table (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .alloc_i     (issue_done && cvxif.resp.x_issue_resp.accept),
    .alloc_id_i  (id_q),
    .alloc_rd_i  (instr_rd(instr_q)),
    .alloc_wb_i  (cvxif.resp.x_issue_resp.writeback),
    .kill_i      (commit_valid_i && commit_kill_i),
    .kill_id_i   (commit_id_i),
    .lookup_i    (result_hs),
    .lookup_id_i (cvxif.resp.x_result.id),
    .full_o      (tbl_full),
    .hit_o       (tbl_hit),
    .dropped_o   (tbl_dropped),
    .match_rd_o  (tbl_rd),
    .match_wb_o  (tbl_wb)
  );

  // Writeback buffer: load on a matching result, otherwise drain on wb_ready_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_q   <= 1'b0;
      wb_id_q      <= '0;
      wb_data_q    <= '0;
      wb_rd_q      <= '0;
      wb_we_q      <= 1'b0;
      wb_exc_q     <= 1'b0;
      wb_exccode_q <= '0;
    end else if (result_hs && tbl_hit) begin
      wb_valid_q   <= 1'b1;
      wb_id_q      <= cvxif.resp.x_result.id;
      wb_data_q    <= cvxif.resp.x_result.data;
      wb_rd_q      <= tbl_rd;
      wb_we_q      <= cvxif.resp.x_result.we && tbl_wb;
      wb_exc_q     <= cvxif.resp.x_result.exc;
      wb_exccode_q <= cvxif.resp.x_result.exccode;
    end else if (wb_ready_i) begin
      wb_valid_q   <= 1'b0;
    end
  end

  assign wb_valid_o   = wb_valid_q;
  assign wb_id_o      = wb_id_q;
  assign wb_data_o    = wb_data_q;
  assign wb_rd_o      = wb_rd_q;
  assign wb_we_o      = wb_we_q;
  assign wb_exc_o     = wb_exc_q;
  assign wb_exccode_o = wb_exccode_q;

  // Request bundle: issue, pass-through commit, memory/compressed tie-offs.
  always_comb begin
    cvxif.req                            = '0;
    cvxif.req.x_issue_valid              = issue_valid;
    cvxif.req.x_issue_req.instr          = instr_q;
    cvxif.req.x_issue_req.id             = id_q;
    cvxif.req.x_issue_req.rs[0]          = rs1_q;
    cvxif.req.x_issue_req.rs[1]          = rs2_q;
    cvxif.req.x_issue_req.rs_valid       = {2{issue_valid}};
    cvxif.req.x_commit_valid             = commit_valid_i;
    cvxif.req.x_commit.id                = commit_id_i;
    cvxif.req.x_commit.x_commit_kill     = commit_kill_i;
    cvxif.req.x_mem_ready                = 1'b1;
    cvxif.req.x_result_ready             = result_ready;
  end

  // Response fields this initiator does not act on.
  assign unused_resp = ^{cvxif.resp.x_compressed_ready, cvxif.resp.x_compressed_resp,
                         cvxif.resp.x_mem_valid, cvxif.resp.x_mem_req,
                         cvxif.resp.x_issue_resp.loadstore, cvxif.resp.x_issue_resp.exc};

endmodule

// File: tb/tb_cvxif_offload_ctrl.sv
// Bench for cvxif_offload_ctrl: plays both the core and the coprocessor.
module tb_cvxif_offload_ctrl;
  import cvxif_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        off_valid_i, off_ready_o;
  logic [31:0] off_instr_i, off_rs1_i, off_rs2_i;
  logic [3:0]  off_id_i, off_done_id_o, commit_id_i, wb_id_o;
  logic        off_done_o, off_accept_o;
  logic        commit_valid_i, commit_kill_i;
  logic        wb_valid_o, wb_ready_i, wb_we_o, wb_exc_o, spurious_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic [5:0]  wb_exccode_o;

  cvxif_offload_ctrl_if cx();

  cvxif_offload_ctrl #(.NrOutstanding(4), .IdWidth(X_ID_WIDTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .off_valid_i(off_valid_i), .off_ready_o(off_ready_o), .off_instr_i(off_instr_i),
    .off_rs1_i(off_rs1_i), .off_rs2_i(off_rs2_i), .off_id_i(off_id_i),
    .off_done_o(off_done_o), .off_accept_o(off_accept_o), .off_done_id_o(off_done_id_o),
    .commit_valid_i(commit_valid_i), .commit_kill_i(commit_kill_i), .commit_id_i(commit_id_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_id_o(wb_id_o), .wb_data_o(wb_data_o),
    .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o), .wb_exc_o(wb_exc_o), .wb_exccode_o(wb_exccode_o),
    .spurious_o(spurious_o), .cvxif(cx)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        v;
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [5:0]  code;
  } wb_t;

  // Reference model: which IDs are live, their rd and writeback flag.
  bit       live [16];
  bit [4:0] m_rd [16];
  bit       m_wb [16];
  int       m_count;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) live[i] = 1'b0;
    m_count = 0;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    off_valid_i = 0; off_instr_i = 0; off_rs1_i = 0; off_rs2_i = 0; off_id_i = 0;
    commit_valid_i = 0; commit_kill_i = 0; commit_id_i = 0; wb_ready_i = 1'b1;
    cx.resp = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
    model_clear();
  endtask

  // Offers one instruction and completes the issue handshake after `delay` stall cycles.
  task automatic issue(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [3:0] id, input bit acc, input bit wb, input int delay,
                       output bit req_ok, output bit tmo, output logic done,
                       output logic acc_o, output logic [3:0] did);
    int n = 0;
    req_ok = 1'b1; tmo = 1'b0; done = 1'b0; acc_o = 1'b0; did = '0;
    while (off_ready_o !== 1'b1 && n < 20) begin step(); n++; end
    if (n >= 20) begin tmo = 1'b1; return; end
    off_valid_i = 1'b1; off_instr_i = instr; off_rs1_i = rs1; off_rs2_i = rs2; off_id_i = id;
    step();
    off_valid_i = 1'b0; off_instr_i = $urandom; off_rs1_i = $urandom; off_rs2_i = $urandom;
    off_id_i = 4'($urandom);
    #1;
    for (int c = 0; c <= delay; c++) begin
      if (cx.req.x_issue_valid !== 1'b1 || cx.req.x_issue_req.instr !== instr ||
          cx.req.x_issue_req.rs[0] !== rs1 || cx.req.x_issue_req.rs[1] !== rs2 ||
          cx.req.x_issue_req.id !== id || off_ready_o !== 1'b0 || off_done_o !== 1'b0)
        req_ok = 1'b0;
      if (c < delay) step();
    end
    cx.resp.x_issue_ready = 1'b1;
    cx.resp.x_issue_resp.accept = acc;
    cx.resp.x_issue_resp.writeback = wb;
    #1;
    done = off_done_o; acc_o = off_accept_o; did = off_done_id_o;
    step();
    cx.resp.x_issue_ready = 1'b0;
    cx.resp.x_issue_resp = '0;
    #1;
  endtask

  // Presents one coprocessor result; returns spurious pulse and the wb port one cycle later.
  task automatic send_result(input logic [3:0] id, input logic [31:0] data, input logic we,
                             input logic exc, input logic [5:0] code,
                             output bit tmo, output logic spur, output wb_t w);
    int n = 0;
    cx.resp.x_result_valid = 1'b1;
    cx.resp.x_result.id = id; cx.resp.x_result.data = data; cx.resp.x_result.rd = 5'($urandom);
    cx.resp.x_result.we = we; cx.resp.x_result.exc = exc; cx.resp.x_result.exccode = code;
    #1;
    while (cx.req.x_result_ready !== 1'b1 && n < 20) begin step(); n++; end
    tmo = (n >= 20);
    spur = spurious_o;
    step();
    cx.resp.x_result_valid = 1'b0;
    #1;
    w.v = wb_valid_o; w.id = wb_id_o; w.data = wb_data_o; w.rd = wb_rd_o;
    w.we = wb_we_o; w.exc = wb_exc_o; w.code = wb_exccode_o;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (off_ready_o !== 1'b1) begin failures++; $display("FAIL reset_off_ready: got %b expected 1", off_ready_o); end
    checks++; if (cx.req.x_issue_valid !== 1'b0 || wb_valid_o !== 1'b0 || off_done_o !== 1'b0 || spurious_o !== 1'b0)
      begin failures++; $display("FAIL reset_outputs: issue_valid=%b wb_valid=%b done=%b spurious=%b expected all 0",
                                 cx.req.x_issue_valid, wb_valid_o, off_done_o, spurious_o); end
    checks++; if (cx.req.x_mem_ready !== 1'b1 || cx.req.x_compressed_valid !== 1'b0 ||
                  cx.req.x_mem_result_valid !== 1'b0 || cx.req.x_mem_resp !== '0)
      begin failures++; $display("FAIL tieoffs: mem_ready=%b cmp_valid=%b memres_valid=%b expected 1/0/0",
                                 cx.req.x_mem_ready, cx.req.x_compressed_valid, cx.req.x_mem_result_valid); end
    checks++; if (cx.req.x_result_ready !== 1'b1) begin failures++; $display("FAIL reset_result_ready: got %b expected 1", cx.req.x_result_ready); end
  endtask

  task automatic test_single_add();
    bit ok, tmo; logic d, a, sp; logic [3:0] did; wb_t w;
    logic [31:0] instr;
    instr = {7'd0, 5'd4, 5'd3, 3'd0, 5'd5, 7'b1111011};
    issue(instr, 32'd3, 32'd4, 4'd2, 1'b1, 1'b1, 0, ok, tmo, d, a, did);
    checks++; if (!ok || tmo) begin failures++; $display("FAIL add_request: req_ok=%b timeout=%b expected 1/0", ok, tmo); end
    checks++; if (d !== 1'b1 || a !== 1'b1 || did !== 4'd2) begin failures++; $display("FAIL add_done: done=%b acc=%b id=%0d expected 1/1/2", d, a, did); end
    checks++; if (off_ready_o !== 1'b1) begin failures++; $display("FAIL add_ready_after: got %b expected 1", off_ready_o); end
    commit_valid_i = 1'b1; commit_kill_i = 1'b0; commit_id_i = 4'd2;
    #1;
    checks++; if (cx.req.x_commit_valid !== 1'b1 || cx.req.x_commit.id !== 4'd2 || cx.req.x_commit.x_commit_kill !== 1'b0)
      begin failures++; $display("FAIL add_commit: valid=%b id=%0d kill=%b expected 1/2/0", cx.req.x_commit_valid, cx.req.x_commit.id, cx.req.x_commit.x_commit_kill); end
    step(); commit_valid_i = 1'b0;
    send_result(4'd2, 32'd7, 1'b1, 1'b0, 6'd0, tmo, sp, w);
    checks++; if (tmo || sp !== 1'b0) begin failures++; $display("FAIL add_result: timeout=%b spurious=%b expected 0/0", tmo, sp); end
    checks++; if (w.v !== 1'b1 || w.id !== 4'd2 || w.rd !== 5'd5 || w.data !== 32'd7 || w.we !== 1'b1)
      begin failures++; $display("FAIL add_wb: v=%b id=%0d rd=%0d data=%0d we=%b expected 1/2/5/7/1", w.v, w.id, w.rd, w.data, w.we); end
    step();
  endtask

  task automatic test_reject();
    bit ok, tmo; logic d, a, sp; logic [3:0] did; wb_t w;
    issue(32'h0000_2F7B, 32'd1, 32'd1, 4'd4, 1'b0, 1'b1, 0, ok, tmo, d, a, did);
    checks++; if (d !== 1'b1 || a !== 1'b0 || did !== 4'd4 || tmo) begin failures++; $display("FAIL reject_done: done=%b acc=%b id=%0d expected 1/0/4", d, a, did); end
    send_result(4'd4, 32'd9, 1'b1, 1'b0, 6'd0, tmo, sp, w);
    checks++; if (sp !== 1'b1 || w.v !== 1'b0) begin failures++; $display("FAIL reject_table_empty: spurious=%b wb_valid=%b expected 1/0", sp, w.v); end
  endtask

  task automatic test_backpressure();
    bit ok, tmo; logic d, a; logic [3:0] did;
    bit stable = 1'b1;
    issue(32'h1234_50FB, 32'hA5A5_0001, 32'h5A5A_0002, 4'd6, 1'b1, 1'b1, 3, ok, tmo, d, a, did);
    checks++; if (!ok || tmo || d !== 1'b1 || a !== 1'b1 || did !== 4'd6)
      begin failures++; $display("FAIL stall_issue: stable=%b done=%b acc=%b id=%0d expected 1/1/1/6", ok, d, a, did); end
    issue(32'h0000_0FFB, 32'd0, 32'd0, 4'd7, 1'b1, 1'b1, 0, ok, tmo, d, a, did);
    wb_ready_i = 1'b0;
    cx.resp.x_result_valid = 1'b1; cx.resp.x_result = '0;
    cx.resp.x_result.id = 4'd6; cx.resp.x_result.data = 32'hAAAA_0006; cx.resp.x_result.we = 1'b1;
    #1;
    checks++; if (cx.req.x_result_ready !== 1'b1) begin failures++; $display("FAIL bp_first_ready: got %b expected 1", cx.req.x_result_ready); end
    step();
    cx.resp.x_result.id = 4'd7; cx.resp.x_result.data = 32'hBBBB_0007;
    #1;
    checks++; if (cx.req.x_result_ready !== 1'b0 || wb_valid_o !== 1'b1 || wb_data_o !== 32'hAAAA_0006)
      begin failures++; $display("FAIL bp_hold: ready=%b wb_valid=%b data=%h expected 0/1/aaaa0006", cx.req.x_result_ready, wb_valid_o, wb_data_o); end
    repeat (2) begin
      step();
      if (cx.req.x_result_ready !== 1'b0 || wb_data_o !== 32'hAAAA_0006 || wb_id_o !== 4'd6) stable = 1'b0;
    end
    checks++; if (!stable) begin failures++; $display("FAIL bp_no_overwrite: wb_data=%h id=%0d expected aaaa0006/6", wb_data_o, wb_id_o); end
    wb_ready_i = 1'b1;
    #1;
    checks++; if (cx.req.x_result_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b expected 1", cx.req.x_result_ready); end
    step();
    cx.resp.x_result_valid = 1'b0;
    #1;
    checks++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'hBBBB_0007 || wb_id_o !== 4'd7 || wb_rd_o !== 5'd31)
      begin failures++; $display("FAIL bp_second: v=%b data=%h id=%0d rd=%0d expected 1/bbbb0007/7/31", wb_valid_o, wb_data_o, wb_id_o, wb_rd_o); end
    step();
    checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL bp_drained: wb_valid=%b expected 0", wb_valid_o); end
  endtask

  task automatic test_full();
    bit ok, tmo; logic d, a, sp; logic [3:0] did; wb_t w;
    for (int k = 0; k < 4; k++)
      issue({20'd0, 5'(k + 10), 7'b1111011}, 32'(k), 32'(k), 4'(8 + k), 1'b1, 1'b1, 0, ok, tmo, d, a, did);
    checks++; if (off_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready: got %b expected 0", off_ready_o); end
    send_result(4'd9, 32'd99, 1'b1, 1'b0, 6'd0, tmo, sp, w);
    checks++; if (w.v !== 1'b1 || w.rd !== 5'd11 || off_ready_o !== 1'b1)
      begin failures++; $display("FAIL full_release: wb_valid=%b rd=%0d ready=%b expected 1/11/1", w.v, w.rd, off_ready_o); end
    for (int k = 0; k < 4; k++) begin
      if (k == 1) continue;
      send_result(4'(8 + k), 32'(k), 1'b0, 1'b1, 6'(k + 1), tmo, sp, w);
      checks++; if (w.v !== 1'b1 || w.id !== 4'(8 + k) || w.we !== 1'b0 || w.exc !== 1'b1 || w.code !== 6'(k + 1))
        begin failures++; $display("FAIL full_drain: v=%b id=%0d we=%b exc=%b code=%0d expected 1/%0d/0/1/%0d", w.v, w.id, w.we, w.exc, w.code, 8 + k, k + 1); end
    end
    step();
  endtask

  task automatic test_kill();
    bit ok, tmo; logic d, a, sp; logic [3:0] did; wb_t w;
    issue(32'h0000_00FB, 32'd1, 32'd2, 4'd1, 1'b1, 1'b1, 0, ok, tmo, d, a, did);
    commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 4'd1;
    #1;
    checks++; if (cx.req.x_commit_valid !== 1'b1 || cx.req.x_commit.x_commit_kill !== 1'b1 || cx.req.x_commit.id !== 4'd1)
      begin failures++; $display("FAIL kill_forward: valid=%b kill=%b id=%0d expected 1/1/1", cx.req.x_commit_valid, cx.req.x_commit.x_commit_kill, cx.req.x_commit.id); end
    step(); commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    send_result(4'd1, 32'd5, 1'b1, 1'b0, 6'd0, tmo, sp, w);
    checks++; if (sp !== 1'b0 || w.v !== 1'b0) begin failures++; $display("FAIL kill_drop: spurious=%b wb_valid=%b expected 0/0", sp, w.v); end
    send_result(4'd9, 32'd5, 1'b1, 1'b0, 6'd0, tmo, sp, w);
    checks++; if (sp !== 1'b1 || w.v !== 1'b0) begin failures++; $display("FAIL spurious_id9: spurious=%b wb_valid=%b expected 1/0", sp, w.v); end
    issue(32'h0000_01FB, 32'd1, 32'd2, 4'd3, 1'b1, 1'b1, 0, ok, tmo, d, a, did);
    commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 4'd3;
    cx.resp.x_result_valid = 1'b1; cx.resp.x_result = '0; cx.resp.x_result.id = 4'd3; cx.resp.x_result.we = 1'b1;
    #1;
    checks++; if (spurious_o !== 1'b0 || cx.req.x_result_ready !== 1'b1)
      begin failures++; $display("FAIL kill_same_cycle: spurious=%b ready=%b expected 0/1", spurious_o, cx.req.x_result_ready); end
    step();
    commit_valid_i = 1'b0; commit_kill_i = 1'b0; cx.resp.x_result_valid = 1'b0;
    #1;
    checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL kill_same_no_wb: wb_valid=%b expected 0", wb_valid_o); end
  endtask

  task automatic test_reset_mid_issue();
    bit ok, tmo; logic d, a, sp; logic [3:0] did; wb_t w;
    issue(32'h0000_02FB, 32'd1, 32'd2, 4'd5, 1'b1, 1'b1, 0, ok, tmo, d, a, did);
    off_valid_i = 1'b1; off_instr_i = 32'h0000_03FB; off_id_i = 4'd6;
    step();
    off_valid_i = 1'b0;
    checks++; if (cx.req.x_issue_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_issue: got %b expected 1", cx.req.x_issue_valid); end
    rst_ni = 1'b0;
    #1;
    checks++; if (cx.req.x_issue_valid !== 1'b0) begin failures++; $display("FAIL rst_async: issue_valid=%b expected 0", cx.req.x_issue_valid); end
    step();
    rst_ni = 1'b1;
    #1;
    checks++; if (off_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin failures++; $display("FAIL rst_release: ready=%b wb_valid=%b expected 1/0", off_ready_o, wb_valid_o); end
    send_result(4'd5, 32'd1, 1'b1, 1'b0, 6'd0, tmo, sp, w);
    checks++; if (sp !== 1'b1 || w.v !== 1'b0) begin failures++; $display("FAIL rst_table_empty: spurious=%b wb_valid=%b expected 1/0", sp, w.v); end
    model_clear();
  endtask

  task automatic test_random();
    bit ok, tmo; logic d, a, sp; logic [3:0] did; wb_t w;
    int op, id; int q[$];
    logic [31:0] instr, data; bit acc, wb; logic we, exc; logic [5:0] code;
    apply_reset();
    for (int it = 0; it < 120; it++) begin
      op = $urandom_range(0, 9);
      q.delete();
      for (int i = 0; i < 16; i++) if (live[i]) q.push_back(i);
      if (op < 4) begin
        checks++; if (off_ready_o !== (m_count < 4)) begin failures++; $display("FAIL rnd_ready: got %b expected %b", off_ready_o, m_count < 4); end
        if (m_count < 4) begin
          do id = $urandom_range(0, 15); while (live[id]);
          instr = $urandom; acc = ($urandom_range(0, 3) != 0); wb = 1'($urandom);
          issue(instr, $urandom, $urandom, 4'(id), acc, wb, $urandom_range(0, 2), ok, tmo, d, a, did);
          checks++; if (!ok || tmo || d !== 1'b1 || a !== acc || did !== 4'(id))
            begin failures++; $display("FAIL rnd_issue: ok=%b tmo=%b done=%b acc=%b id=%0d expected 1/0/1/%b/%0d", ok, tmo, d, a, did, acc, id); end
          if (acc) begin live[id] = 1'b1; m_rd[id] = instr[11:7]; m_wb[id] = wb; m_count++; end
        end
      end else if (op < 7 && q.size() > 0) begin
        id = q[$urandom_range(0, q.size() - 1)];
        data = $urandom; we = 1'($urandom); exc = 1'($urandom); code = 6'($urandom);
        send_result(4'(id), data, we, exc, code, tmo, sp, w);
        checks++; if (tmo || sp !== 1'b0 || w.v !== 1'b1 || w.id !== 4'(id) || w.data !== data || w.rd !== m_rd[id] ||
                      w.we !== (we && m_wb[id]) || w.exc !== exc || w.code !== code)
          begin failures++; $display("FAIL rnd_wb: v=%b id=%0d data=%h rd=%0d we=%b exc=%b code=%0d expected 1/%0d/%h/%0d/%b/%b/%0d",
                                     w.v, w.id, w.data, w.rd, w.we, w.exc, w.code, id, data, m_rd[id], we && m_wb[id], exc, code); end
        live[id] = 1'b0; m_count--;
      end else if (op == 7) begin
        do id = $urandom_range(0, 15); while (live[id]);
        send_result(4'(id), $urandom, 1'b1, 1'b0, 6'd0, tmo, sp, w);
        checks++; if (sp !== 1'b1 || w.v !== 1'b0) begin failures++; $display("FAIL rnd_spurious: spurious=%b wb_valid=%b expected 1/0", sp, w.v); end
      end else if (op == 8 && q.size() > 0) begin
        id = q[$urandom_range(0, q.size() - 1)];
        commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 4'(id);
        step(); commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        live[id] = 1'b0; m_count--;
        checks++; if (off_ready_o !== (m_count < 4)) begin failures++; $display("FAIL rnd_kill_free: ready=%b expected %b", off_ready_o, m_count < 4); end
        send_result(4'(id), $urandom, 1'b1, 1'b0, 6'd0, tmo, sp, w);
        checks++; if (sp !== 1'b0 || w.v !== 1'b0) begin failures++; $display("FAIL rnd_kill_drop: spurious=%b wb_valid=%b expected 0/0", sp, w.v); end
      end else begin
        id = $urandom_range(0, 15);
        commit_valid_i = 1'b1; commit_kill_i = 1'b0; commit_id_i = 4'(id);
        #1;
        checks++; if (cx.req.x_commit_valid !== 1'b1 || cx.req.x_commit.id !== 4'(id) || cx.req.x_commit.x_commit_kill !== 1'b0)
          begin failures++; $display("FAIL rnd_commit: valid=%b id=%0d kill=%b expected 1/%0d/0", cx.req.x_commit_valid, cx.req.x_commit.id, cx.req.x_commit.x_commit_kill, id); end
        step(); commit_valid_i = 1'b0;
      end
      if (wb_valid_o === 1'b1) step();
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_reject();
    test_backpressure();
    test_full();
    test_kill();
    test_reset_mid_issue();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
